// File: rtl/rom_writer_if.sv
// rtl/rom_writer_if.sv - host request and PROM socket signals of the rom_writer programmer.
interface rom_writer_if #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDRESS_WIDTH = 9
);
    logic                     start;
    logic [ADDRESS_WIDTH-1:0] address_in;
    logic [DATA_WIDTH-1:0]    data_in;
    logic [DATA_WIDTH-1:0]    data_line_in;
    logic [3:0]               operation;
    logic [ADDRESS_WIDTH-1:0] address_line;
    logic [DATA_WIDTH-1:0]    program_line;
    logic                     busy;
    logic                     done;
    logic                     error;

    modport master (
        output start, address_in, data_in, data_line_in,
        input  operation, address_line, program_line, busy, done, error
    );

    modport slave (
        input  start, address_in, data_in, data_line_in,
        output operation, address_line, program_line, busy, done, error
    );
endinterface

// File: rtl/rom_writer.sv
// rtl/rom_writer.sv - fusible PROM word programmer; ROM_WRITER_RETRY_EN enables re-pulsing a bit up to MAX_ATTEMPTS times.
module rom_writer #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDRESS_WIDTH = 9,
    parameter int PULSE_CYCLES  = 500,
    parameter int SETTLE_CYCLES = 4,
    parameter int MAX_ATTEMPTS  = 8
) (
    input  logic     clk,
    input  logic     reset_n,
    rom_writer_if.slave bus
);
    localparam int TMAX = (PULSE_CYCLES > SETTLE_CYCLES) ? PULSE_CYCLES : SETTLE_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);
    localparam int IW   = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    typedef enum logic [2:0] {
        IDLE, SETTLE, CHECK, SELECT, PULSE, RECOVER, DONE, FAIL
    } state_t;

    state_t                   state, next_state;
    logic [ADDRESS_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0]    target_q;
    logic [DATA_WIDTH-1:0]    rb_q;
    logic [TW-1:0]            timer;
    logic                     error_q;
    logic [IW-1:0]            pulse_idx;
    logic [IW-1:0]            sel_idx;
    logic [DATA_WIDTH-1:0]    need;
    logic                     sel_fail;

`ifdef ROM_WRITER_RETRY_EN
    localparam int AW = $clog2(MAX_ATTEMPTS + 1);
    logic [AW-1:0] attempts;
    logic [AW-1:0] attempts_base;
    logic          pulse_valid;
`else
    logic [DATA_WIDTH-1:0] pulsed;
`endif

    // Lowest target bit still reading unblown in the last readback.
    always_comb begin
        need    = target_q & ~rb_q;
        sel_idx = '0;
        for (int k = DATA_WIDTH - 1; k >= 0; k--) begin
            if (need[k]) sel_idx = IW'(k);
        end
    end

`ifdef ROM_WRITER_RETRY_EN
    always_comb begin
        attempts_base = (pulse_valid && pulse_idx == sel_idx) ? attempts : '0;
        sel_fail      = (attempts_base == AW'(MAX_ATTEMPTS));
    end
`else
    always_comb begin
        sel_fail = pulsed[sel_idx];
    end
`endif

    always_comb begin
        next_state = state;
        case (state)
            IDLE:            if (bus.start) next_state = SETTLE;
            SETTLE, RECOVER: if (timer == '0) next_state = CHECK;
            CHECK: begin
                if (|(bus.data_line_in & ~target_q))  next_state = FAIL;
                else if (bus.data_line_in == target_q) next_state = DONE;
                else                                   next_state = SELECT;
            end
            SELECT:          next_state = sel_fail ? FAIL : PULSE;
            PULSE:           if (timer == '0) next_state = RECOVER;
            DONE, FAIL:      next_state = IDLE;
            default:         next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            addr_q    <= '0;
            target_q  <= '0;
            rb_q      <= '0;
            timer     <= '0;
            error_q   <= 1'b0;
            pulse_idx <= '0;
`ifdef ROM_WRITER_RETRY_EN
            attempts    <= '0;
            pulse_valid <= 1'b0;
`else
            pulsed      <= '0;
`endif
        end else begin
            state <= next_state;
            if (state != next_state) begin
                case (next_state)
                    SETTLE, RECOVER: timer <= TW'(SETTLE_CYCLES - 1);
                    PULSE:           timer <= TW'(PULSE_CYCLES - 1);
                    default:         timer <= '0;
                endcase
            end else if (timer != '0) begin
                timer <= timer - 1'b1;
            end
            if (state == IDLE && bus.start) begin
                addr_q   <= bus.address_in;
                target_q <= bus.data_in;
                error_q  <= 1'b0;
`ifdef ROM_WRITER_RETRY_EN
                attempts    <= '0;
                pulse_valid <= 1'b0;
`else
                pulsed      <= '0;
`endif
            end
            if (state == CHECK) rb_q <= bus.data_line_in;
            if (state == SELECT && !sel_fail) begin
                pulse_idx <= sel_idx;
`ifdef ROM_WRITER_RETRY_EN
                attempts    <= attempts_base + 1'b1;
                pulse_valid <= 1'b1;
`else
                pulsed[sel_idx] <= 1'b1;
`endif
            end
            if (next_state == FAIL) error_q <= 1'b1;
        end
    end

    // Chip-facing lines decode straight from state so reset releases them instantly.
    always_comb begin
        bus.operation    = 4'b0000;
        bus.program_line = '0;
        case (state)
            SETTLE, CHECK, SELECT, RECOVER: bus.operation = 4'b1100;
            PULSE: begin
                bus.operation    = 4'b1111;
                bus.program_line = DATA_WIDTH'(1) << pulse_idx;
            end
            default: bus.operation = 4'b0000;
        endcase
    end

    assign bus.address_line = addr_q;
    assign bus.busy         = (state == SETTLE) || (state == CHECK) || (state == SELECT)
                           || (state == PULSE) || (state == RECOVER);
    assign bus.done         = (state == DONE);
    assign bus.error        = error_q;
endmodule

// File: doc/rom_writer.md
# rom_writer

Programmer for 556PT5 (3604, 512x8) and 556PT4 (3601, 256x4) fusible PROMs, the write-side counterpart of the ROM reader. Accepts one address/data word per request and burns the required fuses bit by bit: it drives the chip's V1..V4 operation lines, applies timed programming pulses and re-reads the chip after each pulse. It sits between the front-panel/host control logic and the chip socket pins, and it shares the address bus and operation-code conventions with the reader.

## Interface
- DATA_WIDTH, 8: data bits per word (8 for 3604, 4 for 3601)
- ADDRESS_WIDTH, 9: address bits (9 for 3604, 8 for 3601)
- PULSE_CYCLES, 500: clk cycles per programming pulse (10 us at 50 MHz)
- SETTLE_CYCLES, 4: clk cycles of read-mode settling before every check
- MAX_ATTEMPTS, 8: maximum pulses per bit before the word fails

Ports:
- clk  in  1  system clock; single clock domain
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  request strobe; sampled only in IDLE
- address_in  in  ADDRESS_WIDTH  target address, latched on start
- data_in  in  DATA_WIDTH  target word, latched on start
- data_line_in  in  DATA_WIDTH  chip data outputs (readback)
- operation  out  4  V1..V4 drive: 4'b0000 idle, 4'b1100 read, 4'b1111 program
- address_line  out  ADDRESS_WIDTH  chip address, held for the whole request
- program_line  out  DATA_WIDTH  one-hot bit select during a pulse, otherwise 0
- busy  out  1  high from the cycle after start until completion
- done  out  1  one-cycle pulse on success
- error  out  1  level; set on failure, cleared by the next accepted start

## Operation
- States: IDLE, SETTLE, CHECK, SELECT, PULSE, RECOVER, DONE, FAIL.
- IDLE: operation=0000. When start=1, latch address_in and data_in, clear error, clear attempt counter, go to SETTLE.
- SETTLE / RECOVER: operation=1100, program_line=0. Each lasts SETTLE_CYCLES cycles, then goes to CHECK.
- CHECK compares data_line_in (R) against the target (T), in this priority order:
  - any bit with R=1 and T=0 (fuse already blown): go to FAIL;
  - R==T: go to DONE;
  - otherwise: go to SELECT.
- SELECT: choose the lowest index i with T[i]=1 and R[i]=0. If i differs from the previously selected bit, reset the attempt counter to 0. If the counter equals MAX_ATTEMPTS, go to FAIL. Otherwise increment the counter and go to PULSE.
- PULSE: operation=1111 and program_line=(1<<i) for exactly PULSE_CYCLES cycles, then RECOVER.
- DONE: done=1 for one cycle, busy=0, then IDLE.
- FAIL: error=1 (held), busy=0, then IDLE.
- start is ignored while busy.
- Counter widths are $clog2(max+1). Address is not incremented internally; the sequencer owns the address sequence.

## Timing
- Reset values: operation=0000, address_line=0, program_line=0, busy=0, done=0, error=0, state=IDLE.
- Reset is asynchronous. Asserting it mid-PULSE drops operation and program_line in the same instant, with no waiting for a clock edge.
- start high in IDLE at edge N: busy=1 from N+1. SETTLE covers N+1..N+S, CHECK is at N+S+1.
- Immediate match: done pulses at N+S+2. Each pulse iteration adds P+S+2 cycles (SELECT 1, PULSE P, RECOVER S, CHECK 1).
- operation changes only on state boundaries. program_line is nonzero only while operation=1111.

## Configuration
- ROM_WRITER_RETRY_EN defined: failed bits are re-pulsed up to MAX_ATTEMPTS times, as described above.
- ROM_WRITER_RETRY_EN undefined: each bit gets one pulse only. If SELECT picks a bit that has already been pulsed in this request, go to FAIL. The attempt counter is not synthesized.

## Test plan
- Blank chip model (each bit fuses after 1 pulse), target 0xA5 at address 0x1FF, S=4, P=500 -> exactly 4 pulses with program_line 0x01, 0x04, 0x20, 0x80 in that order; address_line=0x1FF throughout; done at N+6+4*506; error=0.
- Chip already reads 0x3C, target 0x3C -> no PULSE entered, operation never 1111, done at N+S+2.
- Target 0x00, chip reads 0x01 -> error=1 at N+S+2, zero pulses, done never asserted.
- Bit 3 never fuses, target 0x08, RETRY_EN defined -> exactly 8 pulses on program_line=0x08, then error=1. RETRY_EN undefined -> exactly 1 pulse, then error=1.
- reset_n dropped 100 cycles into a PULSE -> operation=0000 and program_line=0 immediately (before the next clk edge); busy=0; state IDLE after release.
- Second start while busy, with different address/data -> ignored; address_line and the programmed word match the first request.
